// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats, issue bundle.
// Used by id_stage and imm_gen; the illegal check is enabled by ID_ILLEGAL_CHECK_EN.
package rv32_pkg;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_SUB = 7'b0100000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [7:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  br_funct3;
  } issue_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opc);
    imm_fmt_e fmt;
    case (opc)
      OP_IMM, LOAD, JALR: fmt = IMM_I;
      STORE:              fmt = IMM_S;
      BRANCH:             fmt = IMM_B;
      LUI, AUIPC:         fmt = IMM_U;
      JAL:                fmt = IMM_J;
      default:            fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

  // Bits [1:0] are part of every listed opcode, so compressed encodings also miss here.
  function automatic logic is_known_opcode(input logic [6:0] opc);
    return (opc == OP) || (opc == OP_IMM) || (opc == LUI) || (opc == AUIPC) ||
           (opc == LOAD) || (opc == STORE) || (opc == BRANCH) || (opc == JAL) ||
           (opc == JALR);
  endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// Combinational RV32I immediate generator: instruction word plus format select in,
// sign-extended 32-bit immediate out.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr_i,
  input  imm_fmt_e    fmt_i,
  output logic [31:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'b0};
      IMM_J: imm_o = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes one instruction into ALU operands with a one-deep
// valid/ready output register. Optional illegal-opcode flag: ID_ILLEGAL_CHECK_EN.
module id_stage
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [6:0]  funct7_o,
  output logic [2:0]  funct3_o,
  output logic [7:0]  opcode_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [2:0]  br_funct3_o,
  output logic        illegal_o
);

  logic [6:0]  opc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_val;
  imm_fmt_e    imm_fmt;
  issue_t      issue_next;
  issue_t      issue_reg;
  logic        out_valid_reg;
  logic        accept;

  assign opc        = instr_i[6:0];
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // x0 always reads as zero regardless of what the regfile returns.
  assign rs1_val = (rs1_addr_o == 5'd0) ? 32'd0 : rs1_data_i;
  assign rs2_val = (rs2_addr_o == 5'd0) ? 32'd0 : rs2_data_i;

  assign imm_fmt = imm_fmt_of(opc);

  imm_gen u_imm_gen (
    .instr_i (instr_i),
    .fmt_i   (imm_fmt),
    .imm_o   (imm_val)
  );

  always_comb begin
    issue_next           = '0;
    issue_next.opcode    = {1'b0, opc};
    issue_next.imm       = imm_val;
    issue_next.br_funct3 = instr_i[14:12];
    issue_next.rd        = instr_i[11:7];
    case (opc)
      OP: begin
        issue_next.a      = rs1_val;
        issue_next.b      = rs2_val;
        issue_next.funct7 = instr_i[31:25];
        issue_next.funct3 = instr_i[14:12];
      end
      OP_IMM: begin
        issue_next.a      = rs1_val;
        issue_next.b      = imm_val;
        issue_next.funct3 = instr_i[14:12];
        // Only shifts carry a meaningful funct7 (SRLI vs SRAI).
        if (instr_i[14:12] == 3'b001 || instr_i[14:12] == 3'b101)
          issue_next.funct7 = instr_i[31:25];
      end
      LOAD: begin
        issue_next.a = rs1_val;
        issue_next.b = imm_val;
      end
      STORE: begin
        issue_next.a  = rs1_val;
        issue_next.b  = imm_val;
        issue_next.rd = 5'd0;
      end
      BRANCH: begin
        // ALU computes rs1 - rs2; execute evaluates br_funct3 on the result.
        issue_next.a      = rs1_val;
        issue_next.b      = rs2_val;
        issue_next.funct7 = FUNCT7_SUB;
        issue_next.rd     = 5'd0;
      end
      JALR: begin
        issue_next.a = rs1_val;
        issue_next.b = 32'd4;
      end
      JAL: begin
        issue_next.a = pc_i;
        issue_next.b = 32'd4;
      end
      AUIPC: begin
        issue_next.a = pc_i;
        issue_next.b = imm_val;
      end
      LUI: begin
        issue_next.b = imm_val;
      end
      default: begin
        issue_next.rd = 5'd0;
      end
    endcase
  end

  assign in_ready_o = !out_valid_reg || out_ready_i;
  assign accept     = in_valid_i && in_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      issue_reg     <= '0;
    end else begin
      if (accept)
        issue_reg <= issue_next;
      if (flush_i)
        out_valid_reg <= 1'b0;
      else if (accept)
        out_valid_reg <= 1'b1;
      else if (out_ready_i)
        out_valid_reg <= 1'b0;
    end
  end

`ifdef ID_ILLEGAL_CHECK_EN
  logic illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_reg <= 1'b0;
    else if (accept)
      illegal_reg <= !is_known_opcode(opc);
  end

  assign illegal_o = illegal_reg;
`else
  assign illegal_o = 1'b0;
`endif

  assign out_valid_o = out_valid_reg;
  assign a_o         = issue_reg.a;
  assign b_o         = issue_reg.b;
  assign funct7_o    = issue_reg.funct7;
  assign funct3_o    = issue_reg.funct3;
  assign opcode_o    = issue_reg.opcode;
  assign rd_o        = issue_reg.rd;
  assign imm_o       = issue_reg.imm;
  assign br_funct3_o = issue_reg.br_funct3;

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits, RV32I base only.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid_i  input  1  fetch presents instr_i/pc_i.
REQ-005 in_ready_o  output  1  stage accepts this cycle.
REQ-006 instr_i  input  32  raw instruction word.
REQ-007 pc_i  input  32  address of instr_i.
REQ-008 rs1_addr_o  output  5  regfile read port 1 address, combinational from instr_i[19:15].
REQ-009 rs2_addr_o  output  5  regfile read port 2 address, combinational from instr_i[24:20].
REQ-010 rs1_data_i  input  32  regfile read data 1, same-cycle.
REQ-011 rs2_data_i  input  32  regfile read data 2, same-cycle.
REQ-012 flush_i  input  1  discard registered instruction.
REQ-013 out_valid_o  output  1  registered ALU issue valid.
REQ-014 out_ready_i  input  1  execute stage accepts.
REQ-015 a_o  output  32  ALU operand A.
REQ-016 b_o  output  32  ALU operand B.
REQ-017 funct7_o  output  7  ALU FUNCT_SEVEN.
REQ-018 funct3_o  output  3  ALU FUNCT_THREE.
REQ-019 opcode_o  output  8  ALU OPCODE, {1'b0, instr[6:0]}.
REQ-020 rd_o  output  5  destination register.
REQ-021 imm_o  output  32  sign-extended immediate (I/S/B/U/J per opcode).
REQ-022 br_funct3_o  output  3  raw instr[14:12] for branch-condition evaluation.
REQ-023 illegal_o  output  1  registered instruction is illegal.

Function
REQ-024 Transfer in: in_valid_i && in_ready_o; in_ready_o = !out_valid_o || out_ready_i (combinational).
REQ-025 Latency 1 cycle: accepted instruction appears on outputs next edge with out_valid_o=1.
REQ-026 While out_valid_o && !out_ready_i all outputs hold stable.
REQ-027 Output consumed with no new accept: out_valid_o clears next edge; simultaneous consume+accept keeps out_valid_o=1, back-to-back throughput 1/cycle.
REQ-028 flush_i: out_valid_o=0 next edge, overrides same-cycle accept; in_ready_o unaffected.
REQ-029 Operand A: OP/OP-IMM/LOAD/STORE/BRANCH/JALR = rs1 (0 when rs1_addr=0, ignoring rs1_data_i); AUIPC/JAL = pc_i; LUI = 0.
REQ-030 Operand B: OP/BRANCH = rs2 (0 when rs2_addr=0); JAL/JALR = 32'd4; all others = imm.
REQ-031 funct3_o/funct7_o: OP passes instr fields; OP-IMM passes funct3, funct7=instr[31:25] only for funct3 001/101 else 0; BRANCH funct7=0100000, funct3=000 (subtract); all others 0/0 (add).
REQ-032 rd_o = 0 for STORE and BRANCH; instr[11:7] otherwise.
REQ-033 Immediate sign extension from instr[31]; B/J imm bit 0 = 0; U imm low 12 bits = 0.

Reset
REQ-034 rst_n low: out_valid_o=0, illegal_o=0, a_o/b_o/imm_o/funct7_o/funct3_o/opcode_o/rd_o/br_funct3_o = 0, immediately and asynchronously, including mid-stall; release takes effect on the next clk edge.

Configuration
REQ-035 ID_ILLEGAL_CHECK_EN defined: opcode outside the nine RV32I classes or instr[1:0]!=2'b11 sets illegal_o=1 with A=B=0, rd_o=0, funct 0/0 (NOP); undefined: illegal_o tied 0, same NOP decode, no illegal logic synthesised.

Structure
REQ-036 Shared package rv32_pkg holds opcode localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR) and immediate-format enum.
REQ-037 One sub-module imm_gen (combinational instr -> imm, format select); pipeline register and handshake stay in id_stage.

Verification
REQ-038 addi x5,x1,-1 (0xFFF08293), rs1_data=7 -> next cycle a_o=7, b_o=0xFFFFFFFF, funct3=000, funct7=0, rd_o=5, out_valid_o=1.
REQ-039 sub x3,x1,x2 (0x402081B3), data 10/3 -> funct7=0100000, funct3=000, a_o=10, b_o=3; with rs1 addr 0 and rs1_data=0xDEAD -> a_o=0.
REQ-040 beq, out_ready_i low 3 cycles -> outputs frozen, in_ready_o=0, second instruction accepted the cycle out_ready_i rises, no gap.
REQ-041 flush_i with in_valid_i same cycle -> out_valid_o=0 next edge; rst_n pulsed mid-stall -> all outputs 0 asynchronously.
REQ-042 Word 0x0000007F with ID_ILLEGAL_CHECK_EN -> illegal_o=1, rd_o=0; without macro -> illegal_o=0, rd_o=0.
